enemy_spawn_controller: RTL and testbench

Frame-driven manager for a bank of `enemyPosition` slots. It drives each slot's `isEnemyActive` and the shared `randomSeed`, and reads every slot's X/Y position back. Each frame it scans all slots for player collision and lifetime expiry, then spawns a new enemy on a fixed frame cadence. It sits between the game-state logic and the enemy position generators, and reports hits to the scoring/health logic.

---
 rtl/enemy_spawn_controller.sv | 194 +++++++++++++++++++
 tb/tb_enemy_spawn_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_controller.sv
// Frame-driven enemy slot manager: per-frame collision/lifetime scan over all
// slots followed by a cadence-limited spawn into the lowest free slot.
module enemy_spawn_controller #(
    parameter int unsigned N_ENEMY      = 4,
    parameter int unsigned SPAWN_FRAMES = 60,
    parameter int unsigned LIFETIME     = 600,
    parameter int unsigned HIT_W        = 20,
    parameter int unsigned HIT_H        = 20,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frameTick,
    input  logic                  gameRunning,
    input  logic [9:0]            playerX,
    input  logic [8:0]            playerY,
    input  logic [10*N_ENEMY-1:0] enemyXBus,
    input  logic [9*N_ENEMY-1:0]  enemyYBus,
    output logic [N_ENEMY-1:0]    isEnemyActive,
    output logic [7:0]            randomSeed,
    output logic                  playerHit,
    output logic [7:0]            hitCount,
    output logic [3:0]            activeCount
);
    localparam int unsigned IDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam int unsigned AGE_W = 10;
    localparam int unsigned CNT_W = 8;
    localparam logic [7:0]       SEED_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENEMY - 1);
    localparam logic [AGE_W-1:0] AGE_LAST  = AGE_W'(LIFETIME - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;

    state_t                           state, stateNext;
    logic [IDX_W-1:0]                 idx, idxNext;
    logic [CNT_W-1:0]                 spawnCnt, spawnCntNext;
    logic [N_ENEMY-1:0][AGE_W-1:0]    age, ageNext;
    logic [N_ENEMY-1:0]               cool, coolNext;
    logic [N_ENEMY-1:0]               activeNext;
    logic                             hitNext;
    logic [7:0]                       hitCountNext;
    logic [3:0]                       popCount;

    logic [N_ENEMY-1:0][9:0]          enemyX;
    logic [N_ENEMY-1:0][8:0]          enemyY;
    logic [9:0]                       curX, dx;
    logic [8:0]                       curY, dy;
    logic                             hitNow;
    logic [N_ENEMY-1:0]               eligible, spawnPick;
    logic                             lfsrFb;

    assign enemyX = enemyXBus;
    assign enemyY = enemyYBus;

    // Collision test for the slot currently under scan
    assign curX   = enemyX[idx];
    assign curY   = enemyY[idx];
    assign dx     = (curX >= playerX) ? curX - playerX : playerX - curX;
    assign dy     = (curY >= playerY) ? curY - playerY : playerY - curY;
    assign hitNow = (age[idx] != '0) && (dx < 10'(HIT_W)) && (dy < 9'(HIT_H));

    // Lowest slot that is neither active nor cooling down
    assign eligible  = ~isEnemyActive & ~cool;
    assign spawnPick = eligible & (~eligible + N_ENEMY'(1));

    // XNOR taps 8,6,5,4: the seed 8'hA5 steps to 8'h4B
    assign lfsrFb = ~(randomSeed[7] ^ randomSeed[5] ^ randomSeed[4] ^ randomSeed[3]);

    always_comb begin
        popCount = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            popCount = popCount + 4'(isEnemyActive[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // Next-state logic; a low gameRunning overrides any progress
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        if (!gameRunning) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (frameTick) begin
                        stateNext = SCAN;
                        idxNext   = '0;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        stateNext = SPAWN;
                    end else begin
                        idxNext = idx + IDX_W'(1);
                    end
                end
                SPAWN:   stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Output / slot-state next values
    always_comb begin
        activeNext   = isEnemyActive;
        coolNext     = cool;
        ageNext      = age;
        spawnCntNext = spawnCnt;
        hitNext      = 1'b0;
        hitCountNext = hitCount;
        if (!gameRunning) begin
            coolNext     = cool | isEnemyActive;
            activeNext   = '0;
            spawnCntNext = '0;
        end else begin
            case (state)
                SCAN: begin
                    if (isEnemyActive[idx]) begin
                        if (hitNow) begin
                            activeNext[idx] = 1'b0;
                            coolNext[idx]   = 1'b1;
                            hitNext         = 1'b1;
                            if (hitCount != 8'hFF) begin
                                hitCountNext = hitCount + 8'd1;
                            end
                        end else if (age[idx] == AGE_LAST) begin
                            activeNext[idx] = 1'b0;
                            coolNext[idx]   = 1'b1;
                        end else begin
                            ageNext[idx] = age[idx] + AGE_W'(1);
                        end
                    end else begin
                        coolNext[idx] = 1'b0;
                    end
                end
                SPAWN: begin
                    // At terminal count with no free slot the counter holds
                    if (spawnCnt == CNT_LAST) begin
                        if (eligible != '0) begin
                            activeNext   = isEnemyActive | spawnPick;
                            spawnCntNext = '0;
                            for (int i = 0; i < N_ENEMY; i++) begin
                                if (spawnPick[i]) begin
                                    ageNext[i] = '0;
                                end
                            end
                        end
                    end else begin
                        spawnCntNext = spawnCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            isEnemyActive <= '0;
            cool          <= '0;
            age           <= '0;
            spawnCnt      <= '0;
            playerHit     <= 1'b0;
            hitCount      <= '0;
            activeCount   <= '0;
            randomSeed    <= SEED_INIT;
        end else begin
            isEnemyActive <= activeNext;
            cool          <= coolNext;
            age           <= ageNext;
            spawnCnt      <= spawnCntNext;
            playerHit     <= hitNext;
            hitCount      <= hitCountNext;
            activeCount   <= popCount;
            if (frameTick) begin
                randomSeed <= {randomSeed[6:0], lfsrFb};
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawn_controller.sv
// Directed bench: frame table on a fast-spawn instance, plus reset, game-stop
// and lifetime sequences (the latter on a short-lifetime instance).
module tb_enemy_spawn_controller;
    localparam int unsigned N = 4;
    localparam logic [9:0] FAR_X = 10'd900;
    localparam logic [8:0] FAR_Y = 9'd10;

    typedef struct {
        logic [9:0] px;
        logic [8:0] py;
        logic [9:0] s2x;
        logic [8:0] s2y;
        logic [3:0] expActive;
        logic [8:0] expHits;
        logic [7:0] expHitCount;
    } vec_t;

    logic clk = 1'b0;
    logic rst, frameTick, gameRunning;
    logic [9:0] playerX, slot2X;
    logic [8:0] playerY, slot2Y;
    logic [10*N-1:0] enemyXBus;
    logic [9*N-1:0]  enemyYBus;

    logic [N-1:0] activeA, activeB;
    logic [7:0]   seedA, seedB, hitCountA, hitCountB;
    logic         hitA, hitB;
    logic [3:0]   activeCountA, activeCountB;

    int nChecks = 0;
    int nFail   = 0;

    assign enemyXBus = {10'd800, slot2X, 10'd100, 10'd300};
    assign enemyYBus = {9'd450, slot2Y, 9'd100, 9'd220};

    always #5 clk = ~clk;

    enemy_spawn_controller #(
        .N_ENEMY(N), .SPAWN_FRAMES(3), .LIFETIME(600),
        .HIT_W(20), .HIT_H(20), .LFSR_SEED(8'hA5)
    ) dutA (
        .clk(clk), .rst(rst), .frameTick(frameTick), .gameRunning(gameRunning),
        .playerX(playerX), .playerY(playerY),
        .enemyXBus(enemyXBus), .enemyYBus(enemyYBus),
        .isEnemyActive(activeA), .randomSeed(seedA), .playerHit(hitA),
        .hitCount(hitCountA), .activeCount(activeCountA)
    );

    enemy_spawn_controller #(
        .N_ENEMY(N), .SPAWN_FRAMES(1), .LIFETIME(5),
        .HIT_W(20), .HIT_H(20), .LFSR_SEED(8'hA5)
    ) dutB (
        .clk(clk), .rst(rst), .frameTick(frameTick), .gameRunning(gameRunning),
        .playerX(playerX), .playerY(playerY),
        .enemyXBus(enemyXBus), .enemyYBus(enemyYBus),
        .isEnemyActive(activeB), .randomSeed(seedB), .playerHit(hitB),
        .hitCount(hitCountB), .activeCount(activeCountB)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One frame: tick, then 7 more cycles; bit k of hm = playerHit (dutA) k cycles after the tick
    task automatic runFrame(output logic [8:0] hm, output logic [7:0] seedTick);
        hm = '0;
        frameTick = 1'b1;
        step();
        seedTick = seedA;
        hm[1] = hitA;
        frameTick = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step();
            hm[k] = hitA;
        end
    endtask

    initial begin
        vec_t vecs [21];
        logic [3:0] lifeExp [7];
        logic [8:0] hm;
        logic [7:0] sd;

        rst = 1'b1; frameTick = 1'b0; gameRunning = 1'b1;
        playerX = FAR_X; playerY = FAR_Y; slot2X = 10'd600; slot2Y = 9'd300;

        // Frames 1..15: player far, spawn every 3rd frame until full
        vecs[0]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0000, 9'h000, 8'd0};
        vecs[1]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0000, 9'h000, 8'd0};
        vecs[2]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0001, 9'h000, 8'd0};
        vecs[3]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0001, 9'h000, 8'd0};
        vecs[4]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0001, 9'h000, 8'd0};
        vecs[5]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0011, 9'h000, 8'd0};
        vecs[6]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0011, 9'h000, 8'd0};
        vecs[7]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0011, 9'h000, 8'd0};
        vecs[8]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0111, 9'h000, 8'd0};
        vecs[9]  = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0111, 9'h000, 8'd0};
        vecs[10] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b0111, 9'h000, 8'd0};
        vecs[11] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd0};
        vecs[12] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd0};
        vecs[13] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd0};
        vecs[14] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd0};
        // |dx| = 20 exactly: no hit
        vecs[15] = '{10'd320, 9'd220, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd0};
        // slot0 hit at +2; spawn due but slot0 cooling and the rest busy
        vecs[16] = '{10'd310, 9'd230, 10'd600, 9'd300, 4'b1110, 9'h004, 8'd1};
        // slot0 respawns from the held terminal count
        vecs[17] = '{FAR_X, FAR_Y, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd1};
        // freshly spawned slot0 (age 0) overlaps but cannot hit
        vecs[18] = '{10'd310, 9'd230, 10'd600, 9'd300, 4'b1111, 9'h000, 8'd1};
        // slots 0 and 2 both hit: pulses at +2 and +4
        vecs[19] = '{10'd310, 9'd230, 10'd300, 9'd220, 4'b1010, 9'h014, 8'd3};
        vecs[20] = '{FAR_X, FAR_Y, 10'd300, 9'd220, 4'b1011, 9'h000, 8'd3};

        lifeExp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1110, 4'b1101};

        repeat (2) step();
        check("reset active", 32'(activeA), 32'h0);
        check("reset hit", 32'(hitA), 32'h0);
        check("reset hitCount", 32'(hitCountA), 32'h0);
        check("reset activeCount", 32'(activeCountA), 32'h0);
        check("reset seed", 32'(seedA), 32'hA5);
        rst = 1'b0;
        step();

        for (int i = 0; i < 21; i++) begin
            playerX = vecs[i].px;  playerY = vecs[i].py;
            slot2X  = vecs[i].s2x; slot2Y  = vecs[i].s2y;
            runFrame(hm, sd);
            check($sformatf("frame%0d active", i + 1), 32'(activeA), 32'(vecs[i].expActive));
            check($sformatf("frame%0d hitPulses", i + 1), 32'(hm), 32'(vecs[i].expHits));
            check($sformatf("frame%0d hitCount", i + 1), 32'(hitCountA), 32'(vecs[i].expHitCount));
            check($sformatf("frame%0d activeCount", i + 1), 32'(activeCountA),
                  32'($countones(vecs[i].expActive)));
        end

        // Game stop in the middle of a scan
        playerX = FAR_X; playerY = FAR_Y;
        frameTick = 1'b1; step(); frameTick = 1'b0; step();
        gameRunning = 1'b0;
        step();
        check("gamestop active", 32'(activeA), 32'h0);
        check("gamestop hitCount", 32'(hitCountA), 32'd3);
        gameRunning = 1'b1;
        step();
        check("gamestop activeCount", 32'(activeCountA), 32'h0);
        step();

        // Reset asserted mid-scan
        frameTick = 1'b1; step(); frameTick = 1'b0; step();
        rst = 1'b1;
        step();
        check("midscan rst active", 32'(activeA), 32'h0);
        check("midscan rst hit", 32'(hitA), 32'h0);
        check("midscan rst hitCount", 32'(hitCountA), 32'h0);
        check("midscan rst activeCount", 32'(activeCountA), 32'h0);
        check("midscan rst seed", 32'(seedA), 32'hA5);
        check("midscan rst activeB", 32'(activeB), 32'h0);
        check("midscan rst hitCountB", 32'(hitCountB), 32'h0);
        rst = 1'b0;
        step();
        check("seed idle hold", 32'(seedA), 32'hA5);

        // Lifetime 5 / spawn every frame on dutB
        for (int i = 0; i < 7; i++) begin
            runFrame(hm, sd);
            if (i == 0) begin
                check("seed first tick", 32'(sd), 32'h4B);
            end
            check($sformatf("life frame%0d activeB", i + 1), 32'(activeB), 32'(lifeExp[i]));
        end
        check("life activeCountB", 32'(activeCountB), 32'd3);
        check("life hitCountB", 32'(hitCountB), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
